// File: rtl/mac_seq_ctrl_if.sv
// Job, operand, MAC-drive and result signals shared by mac_seq_ctrl and its environment.
// slave = the sequencer's view, master = the fabric/MAC side.
`ifndef MAC_MIN_WIDTH
`define MAC_MIN_WIDTH 8
`endif
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 4
`endif

interface mac_seq_ctrl_if #(
  parameter int MIN_W  = `MAC_MIN_WIDTH,
  parameter int ACC_W  = `MAC_ACC_WIDTH,
  parameter int CONF_W = `MAC_CONF_WIDTH,
  parameter int LEN_W  = 8
);
  logic                    job_valid;
  logic                    job_ready;
  logic [LEN_W-1:0]        job_len;
  logic [1:0]              job_mode;
  logic [ACC_W-1:0]        job_init;
  logic                    job_abort;

  logic                    op_valid;
  logic                    op_ready;
  logic [4*MIN_W-1:0]      op_a;
  logic [MIN_W-1:0]        op_b;

  logic                    mac_en;
  logic                    mac_load;
  logic [ACC_W+CONF_W-1:0] mac_cfg;
  logic [4*MIN_W-1:0]      mac_a;
  logic [MIN_W-1:0]        mac_b;
  logic [ACC_W-1:0]        mac_c;

  logic                    res_valid;
  logic                    res_ready;
  logic [ACC_W-1:0]        res_data;

  modport slave (
    input  job_valid, job_len, job_mode, job_init, job_abort,
    input  op_valid, op_a, op_b, mac_c, res_ready,
    output job_ready, op_ready, mac_en, mac_load, mac_cfg, mac_a, mac_b,
    output res_valid, res_data
  );

  modport master (
    output job_valid, job_len, job_mode, job_init, job_abort,
    output op_valid, op_a, op_b, mac_c, res_ready,
    input  job_ready, op_ready, mac_en, mac_load, mac_cfg, mac_a, mac_b,
    input  res_valid, res_data
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Job-level sequencer for one MAC: takes a dot-product job, streams operand beats, waits out
// the MAC pipeline and returns the result on valid/ready. MAC_SEQ_PERF_EN adds job/busy counters.
`ifndef MAC_MIN_WIDTH
`define MAC_MIN_WIDTH 8
`endif
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 4
`endif

module mac_seq_ctrl #(
  parameter int MIN_W   = `MAC_MIN_WIDTH,
  parameter int ACC_W   = `MAC_ACC_WIDTH,
  parameter int CONF_W  = `MAC_CONF_WIDTH,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  mac_seq_ctrl_if.slave bus
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [31:0]   perf_jobs,
  output logic [31:0]   perf_busy
`endif
);

  localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [DRN_W-1:0]        drain_cnt_q, drain_cnt_d;
  logic                    first_q, first_d;
  logic                    mac_en_q, mac_en_d;
  logic                    mac_load_q, mac_load_d;
  logic [ACC_W+CONF_W-1:0] mac_cfg_q, mac_cfg_d;
  logic [4*MIN_W-1:0]      mac_a_q, mac_a_d;
  logic [MIN_W-1:0]        mac_b_q, mac_b_d;
  logic [ACC_W-1:0]        res_data_q, res_data_d;

  logic                    job_ready;
  logic                    op_ready;
  logic                    res_valid;
  logic                    beat_acc;
  logic [CONF_W-1:0]       conf;

  always_comb begin
    job_ready = (state_q == IDLE);
    // abort wins over a same-cycle beat, so it masks the operand handshake
    op_ready  = (state_q == RUN) && !bus.job_abort;
    res_valid = (state_q == DONE);
    beat_acc  = bus.op_valid && op_ready;

    conf             = '0;
    conf[1:0]        = bus.job_mode;
    conf[CONF_W-1]   = 1'b1;

    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    first_d     = first_q;
    mac_en_d    = 1'b0;
    mac_load_d  = 1'b0;
    mac_cfg_d   = mac_cfg_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    res_data_d  = res_data_q;

    unique case (state_q)
      IDLE: begin
        if (bus.job_valid) begin
          mac_cfg_d = {bus.job_init, conf};
          if (bus.job_len == '0) begin
            res_data_d = bus.job_init;
            state_d    = DONE;
          end else begin
            beat_cnt_d = bus.job_len;
            first_d    = 1'b1;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        if (bus.job_abort) begin
          state_d = IDLE;
        end else if (beat_acc) begin
          mac_en_d   = 1'b1;
          mac_load_d = first_q;
          mac_a_d    = bus.op_a;
          mac_b_d    = bus.op_b;
          first_d    = 1'b0;
          beat_cnt_d = beat_cnt_q - 1'b1;
          if (beat_cnt_q == LEN_W'(1)) begin
            drain_cnt_d = DRN_W'(MAC_LAT);
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        // counter hits zero in the cycle mac_c first reflects the last beat
        if (bus.job_abort) begin
          state_d = IDLE;
        end else if (drain_cnt_q == '0) begin
          res_data_d = bus.mac_c;
          state_d    = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      first_q     <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_load_q  <= 1'b0;
      mac_cfg_q   <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      first_q     <= first_d;
      mac_en_q    <= mac_en_d;
      mac_load_q  <= mac_load_d;
      mac_cfg_q   <= mac_cfg_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.job_ready = job_ready;
  assign bus.op_ready  = op_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.mac_load  = mac_load_q;
  assign bus.mac_cfg   = mac_cfg_q;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;

`ifdef MAC_SEQ_PERF_EN
  logic [31:0] perf_jobs_q, perf_jobs_d;
  logic [31:0] perf_busy_q, perf_busy_d;

  always_comb begin
    perf_jobs_d = perf_jobs_q + ((res_valid && bus.res_ready) ? 32'd1 : 32'd0);
    perf_busy_d = perf_busy_q + (((state_q == RUN) || (state_q == DRAIN)) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_jobs_q <= '0;
      perf_busy_q <= '0;
    end else begin
      perf_jobs_q <= perf_jobs_d;
      perf_busy_q <= perf_busy_d;
    end
  end

  assign perf_jobs = perf_jobs_q;
  assign perf_busy = perf_busy_q;
`endif

endmodule
